// File: rtl/mult_pipe_chain.sv
// Multiplier-datapath pipeline register chain: carries result, destination, write enable,
// instruction and PC from issue to writeback, with stall, kill, occupancy and hazard query.
module mult_pipe_chain #(
    parameter int STAGES = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_we_i,
    input  logic [DATA_W-1:0] in_instr_i,
    input  logic [DATA_W-1:0] in_pc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_we_o,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [DATA_W-1:0] out_pc_o,
    input  logic [ADDR_W-1:0] query_addr_i,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] we_reg;
    logic [DATA_W-1:0] data_reg  [STAGES];
    logic [ADDR_W-1:0] addr_reg  [STAGES];
    logic [DATA_W-1:0] instr_reg [STAGES];
    logic [DATA_W-1:0] pc_reg    [STAGES];
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [STAGES-1:0] hit;

    // Occupancy changes only by what enters stage 0 minus what retires from the last stage.
    assign count_next = count_reg + CNT_W'(in_valid_i) - CNT_W'(valid_reg[STAGES-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i || kill_i) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_reg[i] <= 1'b0;
                we_reg[i]    <= 1'b0;
                data_reg[i]  <= '0;
                addr_reg[i]  <= '0;
                instr_reg[i] <= '0;
                pc_reg[i]    <= '0;
            end
            count_reg <= '0;
        end else if (!stall_i) begin
            // A bubble enters with every field zeroed so invalid stages never carry stale data.
            valid_reg[0] <= in_valid_i;
            we_reg[0]    <= in_valid_i & in_we_i;
            data_reg[0]  <= in_valid_i ? in_data_i  : '0;
            addr_reg[0]  <= in_valid_i ? in_addr_i  : '0;
            instr_reg[0] <= in_valid_i ? in_instr_i : '0;
            pc_reg[0]    <= in_valid_i ? in_pc_i    : '0;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                we_reg[i]    <= we_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
                addr_reg[i]  <= addr_reg[i-1];
                instr_reg[i] <= instr_reg[i-1];
                pc_reg[i]    <= pc_reg[i-1];
            end
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_hit
            assign hit[gi] = valid_reg[gi] && we_reg[gi] && (addr_reg[gi] == query_addr_i);
        end
    endgenerate

    // Register x0 is hardwired zero, so a pending write to it is never a hazard.
    assign hazard_o    = (|hit) && (query_addr_i != '0);

    assign out_valid_o = valid_reg[STAGES-1];
    assign out_we_o    = valid_reg[STAGES-1] & we_reg[STAGES-1];
    assign out_data_o  = data_reg[STAGES-1];
    assign out_addr_o  = addr_reg[STAGES-1];
    assign out_instr_o = instr_reg[STAGES-1];
    assign out_pc_o    = pc_reg[STAGES-1];

    assign count_o     = count_reg;
    assign empty_o     = (count_reg == '0);
    assign full_o      = (count_reg == CNT_W'(STAGES));

endmodule
